// File: rtl/fuzzy_surface_sweeper.sv
// ----------------------------------------------------------------------------
// fuzzy_surface_sweeper
//   Grid-sweep engine for a two-input fuzzy controller core. Walks Entrada_01
//   (outer axis, index i) and Entrada_02 (inner axis, index j) over a clamped
//   grid of NPTS x NPTS points. Each point is held for a settle time (or until
//   the core strobes core_done). The core output is then captured and streamed
//   out as (i, j, result) beats on a valid/ready port.
//
// Ports
//   clk_0          in   1   sole clock, rising edge
//   Srst_n         in   1   asynchronous active-low reset
//   start          in   1   one-cycle pulse, starts a sweep when idle
//   abort          in   1   ends any sweep, back to idle next cycle
//   Entrada_01     out  W   core input 1 (outer axis)
//   Entrada_02     out  W   core input 2 (inner axis)
//   core_done      in   1   core result strobe, used when USE_DONE=1
//   saida_defuzzy  in   W   core defuzzified output
//   res_valid      out  1   result beat valid
//   res_ready      in   1   downstream accepts the beat
//   res_data       out  W   captured saida_defuzzy
//   res_i, res_j   out  IW  grid indices of the beat
//   busy           out  1   sweep in progress
//   done           out  1   one-cycle pulse after the last beat is accepted
// ----------------------------------------------------------------------------
module fuzzy_surface_sweeper #(
   parameter int unsigned  W          = 8,
   parameter int unsigned  STEP       = 16,
   parameter int unsigned  MIN_CLAMP  = 1,
   parameter int unsigned  MAX_CLAMP  = 254,
   parameter int unsigned  SETTLE_CYC = 14,
   parameter bit           USE_DONE   = 1'b0,
   localparam int unsigned NPTS       = (2 ** W) / STEP + 1,
   localparam int unsigned IW         = $clog2(NPTS)
) (
   input  logic          clk_0,
   input  logic          Srst_n,
   input  logic          start,
   input  logic          abort,
   output logic [W-1:0]  Entrada_01,
   output logic [W-1:0]  Entrada_02,
   input  logic          core_done,
   input  logic [W-1:0]  saida_defuzzy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [W-1:0]  res_data,
   output logic [IW-1:0] res_i,
   output logic [IW-1:0] res_j,
   output logic          busy,
   output logic          done
);

   // STEP is a power of two, so idx*STEP is a left shift.
   localparam int unsigned SHIFT = $clog2(STEP);
   localparam int unsigned CW    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

   localparam logic [IW-1:0] LAST_IDX = IW'(NPTS - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE_CYC - 1);
   localparam logic [W:0]    MIN_RAW  = (W+1)'(MIN_CLAMP);
   localparam logic [W:0]    MAX_RAW  = (W+1)'(MAX_CLAMP);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_APPLY   = 3'd1,
      S_WAIT    = 3'd2,
      S_CAPTURE = 3'd3,
      S_EMIT    = 3'd4,
      S_FINISH  = 3'd5
   } state_t;

   // Registered state
   state_t        r_state;
   logic [IW-1:0] r_i;
   logic [IW-1:0] r_j;
   logic [CW-1:0] r_cnt;
   logic [W-1:0]  r_in1;
   logic [W-1:0]  r_in2;
   logic          r_valid;
   logic [W-1:0]  r_data;
   logic [IW-1:0] r_res_i;
   logic [IW-1:0] r_res_j;
   logic          r_busy;
   logic          r_done;

   // Next-state values
   state_t        w_state_nxt;
   logic [IW-1:0] w_i_nxt;
   logic [IW-1:0] w_j_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [W-1:0]  w_in1_nxt;
   logic [W-1:0]  w_in2_nxt;
   logic          w_valid_nxt;
   logic [W-1:0]  w_data_nxt;
   logic [IW-1:0] w_res_i_nxt;
   logic [IW-1:0] w_res_j_nxt;
   logic          w_busy_nxt;
   logic          w_done_nxt;

   logic          w_last_point;
   logic          w_settled;

   // Map a grid index to the clamped value driven to the core.
   function automatic logic [W-1:0] axis_value(input logic [IW-1:0] idx);
      logic [W:0] raw;
      raw = (W+1)'(idx) << SHIFT;
      if (raw < MIN_RAW) begin
         axis_value = W'(MIN_CLAMP);
      end else if (raw > MAX_RAW) begin
         axis_value = W'(MAX_CLAMP);
      end else begin
         axis_value = W'(raw);
      end
   endfunction

   assign w_last_point = (r_i == LAST_IDX) && (r_j == LAST_IDX);

   // End of the wait window: either the core strobe or the settle counter.
   assign w_settled = USE_DONE ? core_done : (r_cnt == LAST_CNT);

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_i_nxt     = r_i;
      w_j_nxt     = r_j;
      w_cnt_nxt   = r_cnt;
      w_in1_nxt   = r_in1;
      w_in2_nxt   = r_in2;
      w_valid_nxt = r_valid;
      w_data_nxt  = r_data;
      w_res_i_nxt = r_res_i;
      w_res_j_nxt = r_res_j;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;

      if (abort && (r_state != S_IDLE)) begin
         // Abort wins over a same-cycle accept; core inputs keep their values.
         w_state_nxt = S_IDLE;
         w_valid_nxt = 1'b0;
         w_busy_nxt  = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !abort) begin
                  w_i_nxt     = '0;
                  w_j_nxt     = '0;
                  w_busy_nxt  = 1'b1;
                  w_state_nxt = S_APPLY;
               end
            end
            S_APPLY: begin
               w_in1_nxt   = axis_value(r_i);
               w_in2_nxt   = axis_value(r_j);
               w_cnt_nxt   = '0;
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (w_settled) begin
                  w_state_nxt = S_CAPTURE;
               end else begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               w_data_nxt  = saida_defuzzy;
               w_res_i_nxt = r_i;
               w_res_j_nxt = r_j;
               w_valid_nxt = 1'b1;
               w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
               // res_valid is always high here, so ready alone is the accept.
               if (res_ready) begin
                  w_valid_nxt = 1'b0;
                  if (w_last_point) begin
                     w_done_nxt  = 1'b1;
                     w_state_nxt = S_FINISH;
                  end else begin
                     w_state_nxt = S_APPLY;
                     if (r_j == LAST_IDX) begin
                        w_j_nxt = '0;
                        w_i_nxt = r_i + 1'b1;
                     end else begin
                        w_j_nxt = r_j + 1'b1;
                     end
                  end
               end
            end
            S_FINISH: begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
               w_busy_nxt  = 1'b0;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge clk_0 or negedge Srst_n) begin
      if (!Srst_n) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_j     <= '0;
         r_cnt   <= '0;
         r_in1   <= W'(MIN_CLAMP);
         r_in2   <= W'(MIN_CLAMP);
         r_valid <= 1'b0;
         r_data  <= '0;
         r_res_i <= '0;
         r_res_j <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_i     <= w_i_nxt;
         r_j     <= w_j_nxt;
         r_cnt   <= w_cnt_nxt;
         r_in1   <= w_in1_nxt;
         r_in2   <= w_in2_nxt;
         r_valid <= w_valid_nxt;
         r_data  <= w_data_nxt;
         r_res_i <= w_res_i_nxt;
         r_res_j <= w_res_j_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign Entrada_01 = r_in1;
   assign Entrada_02 = r_in2;
   assign res_valid  = r_valid;
   assign res_data   = r_data;
   assign res_i      = r_res_i;
   assign res_j      = r_res_j;
   assign busy       = r_busy;
   assign done       = r_done;

endmodule

// File: tb/tb_fuzzy_surface_sweeper.sv
// ----------------------------------------------------------------------------
// tb_fuzzy_surface_sweeper
//   Bench for fuzzy_surface_sweeper with three instances: default grid
//   (STEP=16), coarse grid (STEP=64), and coarse grid in core_done mode.
//   Expected beats come from a row-major grid model using plain arithmetic.
// ----------------------------------------------------------------------------
module tb_fuzzy_surface_sweeper;

   localparam int NA = 17;   // points per axis, STEP=16
   localparam int NS = 5;    // points per axis, STEP=64

   logic clk = 1'b0;
   logic Srst_n;
   always #5 clk = ~clk;

   int n_err = 0;
   int n_chk = 0;

   // Default instance
   logic       st_a, ab_a, cd_a, rdy_a, v_a, busy_a, done_a;
   logic [7:0] e1_a, e2_a, sd_a, d_a;
   logic [4:0] ri_a, rj_a;

   // STEP=64 instance
   logic       st_s, ab_s, cd_s, rdy_s, v_s, busy_s, done_s;
   logic [7:0] e1_s, e2_s, sd_s, d_s;
   logic [2:0] ri_s, rj_s;

   // STEP=64, USE_DONE=1 instance
   logic       st_u, ab_u, cd_u, rdy_u, v_u, busy_u, done_u;
   logic [7:0] e1_u, e2_u, sd_u, d_u;
   logic [2:0] ri_u, rj_u;

   // Stand-in fuzzy surface: any function of both inputs that separates points.
   function automatic logic [7:0] fz(input logic [7:0] a, input logic [7:0] b);
      return 8'(a * 8'd7 + b * 8'd3 + (a ^ b));
   endfunction

   // Clamped axis value for a grid index.
   function automatic int axis(input int idx, input int step);
      int raw;
      raw = idx * step;
      if (raw < 1)   return 1;
      if (raw > 254) return 254;
      return raw;
   endfunction

   assign sd_a = fz(e1_a, e2_a);
   assign sd_s = fz(e1_s, e2_s);

   fuzzy_surface_sweeper u_dut_a (
      .clk_0(clk), .Srst_n(Srst_n), .start(st_a), .abort(ab_a),
      .Entrada_01(e1_a), .Entrada_02(e2_a), .core_done(cd_a), .saida_defuzzy(sd_a),
      .res_valid(v_a), .res_ready(rdy_a), .res_data(d_a), .res_i(ri_a), .res_j(rj_a),
      .busy(busy_a), .done(done_a));

   fuzzy_surface_sweeper #(.STEP(64)) u_dut_s (
      .clk_0(clk), .Srst_n(Srst_n), .start(st_s), .abort(ab_s),
      .Entrada_01(e1_s), .Entrada_02(e2_s), .core_done(cd_s), .saida_defuzzy(sd_s),
      .res_valid(v_s), .res_ready(rdy_s), .res_data(d_s), .res_i(ri_s), .res_j(rj_s),
      .busy(busy_s), .done(done_s));

   fuzzy_surface_sweeper #(.STEP(64), .USE_DONE(1'b1)) u_dut_u (
      .clk_0(clk), .Srst_n(Srst_n), .start(st_u), .abort(ab_u),
      .Entrada_01(e1_u), .Entrada_02(e2_u), .core_done(cd_u), .saida_defuzzy(sd_u),
      .res_valid(v_u), .res_ready(rdy_u), .res_data(d_u), .res_i(ri_u), .res_j(rj_u),
      .busy(busy_u), .done(done_u));

   task automatic test_reset();
      n_chk++;
      if (e1_a !== 8'd1 || e2_a !== 8'd1 || v_a !== 1'b0 || d_a !== 8'd0 ||
          ri_a !== 5'd0 || rj_a !== 5'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_err++;
         $display("FAIL reset_a: got e1=%0d e2=%0d v=%b d=%0d i=%0d j=%0d busy=%b done=%b, need 1 1 0 0 0 0 0 0",
                  e1_a, e2_a, v_a, d_a, ri_a, rj_a, busy_a, done_a);
      end
      n_chk++;
      if (e1_s !== 8'd1 || e2_s !== 8'd1 || v_s !== 1'b0 || busy_s !== 1'b0 ||
          e1_u !== 8'd1 || e2_u !== 8'd1 || v_u !== 1'b0 || busy_u !== 1'b0) begin
         n_err++;
         $display("FAIL reset_su: got s=(%0d,%0d,v%b,b%b) u=(%0d,%0d,v%b,b%b), need (1,1,v0,b0)",
                  e1_s, e2_s, v_s, busy_s, e1_u, e2_u, v_u, busy_u);
      end
   endtask

   // Full or partial sweep on the default instance.
   //   ready_pct  : chance of res_ready per cycle (also injects stray starts when <100)
   //   chk_time   : check 17-cycle per-point cadence (needs ready_pct=100)
   //   abort_beat : beat index at which abort is raised together with ready (-1: none)
   task automatic test_sweep(input int ready_pct, input bit chk_time, input int abort_beat);
      int k, cyc, ei, ej, e1, e2, x1, x2;
      bit stall;
      logic [7:0] h_d, h_e1, h_e2;
      logic [4:0] h_i, h_j;
      k = 0; cyc = 0; stall = 1'b0;
      h_d = '0; h_e1 = '0; h_e2 = '0; h_i = '0; h_j = '0;
      st_a = 1'b1; rdy_a = 1'b0;
      @(negedge clk); st_a = 1'b0; cyc = 1;
      while (k < NA * NA && cyc < 20000) begin
         rdy_a = ($urandom_range(0, 99) < ready_pct);
         st_a  = (ready_pct < 100) && ($urandom_range(0, 19) == 0);
         n_chk++;
         if (busy_a !== 1'b1 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL sweep_busy: beat %0d cyc %0d got busy=%b done=%b, need busy=1 done=0",
                     k, cyc, busy_a, done_a);
         end
         if (stall) begin
            n_chk++;
            if (v_a !== 1'b1 || d_a !== h_d || ri_a !== h_i || rj_a !== h_j ||
                e1_a !== h_e1 || e2_a !== h_e2) begin
               n_err++;
               $display("FAIL stall_stable: beat %0d got v=%b d=%0d i=%0d j=%0d in=(%0d,%0d), need v=1 d=%0d i=%0d j=%0d in=(%0d,%0d)",
                        k, v_a, d_a, ri_a, rj_a, e1_a, e2_a, h_d, h_i, h_j, h_e1, h_e2);
            end
         end
         if (v_a === 1'b1) begin
            ei = k / NA; ej = k % NA;
            e1 = axis(ei, 16); e2 = axis(ej, 16);
            n_chk++;
            if (d_a !== fz(8'(e1), 8'(e2)) || ri_a !== 5'(ei) || rj_a !== 5'(ej) ||
                e1_a !== 8'(e1) || e2_a !== 8'(e2)) begin
               n_err++;
               $display("FAIL beat: #%0d got d=%0d i=%0d j=%0d in=(%0d,%0d), need d=%0d i=%0d j=%0d in=(%0d,%0d)",
                        k, d_a, ri_a, rj_a, e1_a, e2_a, fz(8'(e1), 8'(e2)), ei, ej, e1, e2);
            end
            case (k)
               0:       begin x1 = 1;   x2 = 1;   end
               1:       begin x1 = 1;   x2 = 16;  end
               16:      begin x1 = 1;   x2 = 254; end
               288:     begin x1 = 254; x2 = 254; end
               default: begin x1 = -1;  x2 = -1;  end
            endcase
            if (x1 >= 0) begin
               n_chk++;
               if (e1_a !== 8'(x1) || e2_a !== 8'(x2)) begin
                  n_err++;
                  $display("FAIL landmark: beat %0d got (%0d,%0d), need (%0d,%0d)", k, e1_a, e2_a, x1, x2);
               end
            end
            if (k == abort_beat) begin
               rdy_a = 1'b1; ab_a = 1'b1; st_a = 1'b0;
               @(negedge clk);
               ab_a = 1'b0; rdy_a = 1'b0;
               n_chk++;
               if (v_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0 ||
                   e1_a !== 8'(e1) || e2_a !== 8'(e2)) begin
                  n_err++;
                  $display("FAIL abort: got v=%b busy=%b done=%b in=(%0d,%0d), need v=0 busy=0 done=0 in=(%0d,%0d)",
                           v_a, busy_a, done_a, e1_a, e2_a, e1, e2);
               end
               x1 = 0;
               repeat (30) begin
                  @(negedge clk);
                  if (v_a !== 1'b0 || done_a !== 1'b0 || busy_a !== 1'b0) x1++;
               end
               n_chk++;
               if (x1 != 0) begin
                  n_err++;
                  $display("FAIL abort_quiet: got %0d active cycles after abort, need 0", x1);
               end
               return;
            end
            stall = !rdy_a;
            h_d = d_a; h_i = ri_a; h_j = rj_a; h_e1 = e1_a; h_e2 = e2_a;
            if (rdy_a) begin
               if (chk_time) begin
                  n_chk++;
                  if (cyc != 17 * (k + 1)) begin
                     n_err++;
                     $display("FAIL cadence: beat %0d accepted at cycle %0d, need %0d", k, cyc, 17 * (k + 1));
                  end
               end
               k++;
            end
         end
         @(negedge clk); cyc++;
      end
      st_a = 1'b0; rdy_a = 1'b0;
      n_chk++;
      if (cyc >= 20000) begin
         n_err++;
         $display("FAIL sweep_timeout: got %0d beats, need %0d", k, NA * NA);
      end else if (done_a !== 1'b1) begin
         n_err++;
         $display("FAIL done_pulse: got done=%b one cycle after last accept, need 1", done_a);
      end
      @(negedge clk);
      n_chk++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || v_a !== 1'b0) begin
         n_err++;
         $display("FAIL sweep_end: got done=%b busy=%b v=%b, need 0 0 0", done_a, busy_a, v_a);
      end
   endtask

   task automatic test_step64();
      int ax[5] = '{1, 64, 128, 192, 254};
      int k, cyc, ei, ej;
      logic [7:0] exp_d;
      k = 0; cyc = 0;
      st_s = 1'b1; rdy_s = 1'b1;
      @(negedge clk); st_s = 1'b0; cyc = 1;
      while (k < NS * NS && cyc < 2000) begin
         if (v_s === 1'b1) begin
            ei = k / NS; ej = k % NS;
            exp_d = fz(8'(ax[ei]), 8'(ax[ej]));
            n_chk++;
            if (e1_s !== 8'(ax[ei]) || e2_s !== 8'(ax[ej]) || ri_s !== 3'(ei) ||
                rj_s !== 3'(ej) || d_s !== exp_d) begin
               n_err++;
               $display("FAIL step64_beat: #%0d got in=(%0d,%0d) i=%0d j=%0d d=%0d, need in=(%0d,%0d) i=%0d j=%0d d=%0d",
                        k, e1_s, e2_s, ri_s, rj_s, d_s, ax[ei], ax[ej], ei, ej, exp_d);
            end
            k++;
         end
         @(negedge clk); cyc++;
      end
      rdy_s = 1'b0;
      n_chk++;
      if (cyc >= 2000 || done_s !== 1'b1 || cyc != NS * NS * 17 + 1) begin
         n_err++;
         $display("FAIL step64_done: got beats=%0d done=%b at cycle %0d, need beats=25 done=1 at cycle %0d",
                  k, done_s, cyc, NS * NS * 17 + 1);
      end
      @(negedge clk);
      n_chk++;
      if (done_s !== 1'b0 || busy_s !== 1'b0) begin
         n_err++;
         $display("FAIL step64_end: got done=%b busy=%b, need 0 0", done_s, busy_s);
      end
   endtask

   task automatic test_start_abort_idle();
      int act;
      st_a = 1'b1; ab_a = 1'b1;
      @(negedge clk);
      st_a = 1'b0; ab_a = 1'b0;
      n_chk++;
      if (busy_a !== 1'b0) begin
         n_err++;
         $display("FAIL start_abort_idle: got busy=%b, need 0", busy_a);
      end
      act = 0;
      repeat (20) begin
         @(negedge clk);
         if (v_a !== 1'b0 || busy_a !== 1'b0 || e1_a !== 8'd1 || e2_a !== 8'd48) act++;
      end
      n_chk++;
      if (act != 0) begin
         n_err++;
         $display("FAIL start_abort_quiet: got %0d active cycles, need 0", act);
      end
   endtask

   task automatic test_reset_mid_wait();
      int acc, cyc;
      acc = 0; cyc = 0;
      st_a = 1'b1; rdy_a = 1'b1;
      @(negedge clk); st_a = 1'b0;
      while (acc < 3 && cyc < 200) begin
         if (v_a === 1'b1) acc++;
         @(negedge clk); cyc++;
      end
      rdy_a = 1'b0;
      n_chk++;
      if (cyc >= 200) begin
         n_err++;
         $display("FAIL reset_setup_timeout: got %0d beats, need 3", acc);
      end
      repeat (3) @(negedge clk);
      n_chk++;
      if (e1_a !== 8'd1 || e2_a !== 8'd48 || busy_a !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset: got in=(%0d,%0d) busy=%b, need (1,48) busy=1", e1_a, e2_a, busy_a);
      end
      #2 Srst_n = 1'b0;
      #1;
      n_chk++;
      if (e1_a !== 8'd1 || e2_a !== 8'd1 || v_a !== 1'b0 || d_a !== 8'd0 ||
          ri_a !== 5'd0 || rj_a !== 5'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: got e1=%0d e2=%0d v=%b d=%0d i=%0d j=%0d busy=%b done=%b, need 1 1 0 0 0 0 0 0",
                  e1_a, e2_a, v_a, d_a, ri_a, rj_a, busy_a, done_a);
      end
      @(negedge clk); Srst_n = 1'b1;
      repeat (20) @(negedge clk);
      n_chk++;
      if (busy_a !== 1'b0 || v_a !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: got busy=%b v=%b, need 0 0", busy_a, v_a);
      end
   endtask

   // core_done mode: saida is only correct in the cycle after the strobe.
   task automatic test_use_done();
      int ax[5] = '{1, 64, 128, 192, 254};
      int ei, ej, dly;
      logic [7:0] good;
      st_u = 1'b1; rdy_u = 1'b0; cd_u = 1'b0;
      @(negedge clk); st_u = 1'b0;
      for (int p = 0; p < NS * NS; p++) begin
         ei = p / NS; ej = p % NS;
         good = fz(8'(ax[ei]), 8'(ax[ej]));
         @(negedge clk);
         sd_u = ~good;
         n_chk++;
         if (e1_u !== 8'(ax[ei]) || e2_u !== 8'(ax[ej])) begin
            n_err++;
            $display("FAIL done_inputs: point %0d got (%0d,%0d), need (%0d,%0d)", p, e1_u, e2_u, ax[ei], ax[ej]);
         end
         dly = $urandom_range(3, 50);
         repeat (dly - 1) @(negedge clk);
         cd_u = 1'b1;
         @(negedge clk);
         cd_u = 1'b0; sd_u = good;
         @(negedge clk);
         sd_u = ~good;
         n_chk++;
         if (v_u !== 1'b1 || d_u !== good || ri_u !== 3'(ei) || rj_u !== 3'(ej)) begin
            n_err++;
            $display("FAIL done_capture: point %0d delay %0d got v=%b d=%0d i=%0d j=%0d, need v=1 d=%0d i=%0d j=%0d",
                     p, dly, v_u, d_u, ri_u, rj_u, good, ei, ej);
         end
         cd_u = 1'b1;
         @(negedge clk);
         cd_u = 1'b0;
         n_chk++;
         if (v_u !== 1'b1 || d_u !== good) begin
            n_err++;
            $display("FAIL stray_done: point %0d got v=%b d=%0d, need v=1 d=%0d", p, v_u, d_u, good);
         end
         rdy_u = 1'b1;
         @(negedge clk);
         rdy_u = 1'b0;
      end
      n_chk++;
      if (done_u !== 1'b1) begin
         n_err++;
         $display("FAIL done_mode_pulse: got done=%b, need 1", done_u);
      end
      @(negedge clk);
      n_chk++;
      if (done_u !== 1'b0 || busy_u !== 1'b0) begin
         n_err++;
         $display("FAIL done_mode_end: got done=%b busy=%b, need 0 0", done_u, busy_u);
      end
   endtask

   initial begin
      Srst_n = 1'b0;
      st_a = 1'b0; ab_a = 1'b0; cd_a = 1'b0; rdy_a = 1'b0;
      st_s = 1'b0; ab_s = 1'b0; cd_s = 1'b0; rdy_s = 1'b0;
      st_u = 1'b0; ab_u = 1'b0; cd_u = 1'b0; rdy_u = 1'b0; sd_u = 8'd0;
      repeat (3) @(negedge clk);
      Srst_n = 1'b1;
      @(negedge clk);

      test_reset();
      test_sweep(100, 1'b1, -1);
      test_sweep(50, 1'b0, -1);
      test_step64();
      test_sweep(100, 1'b0, 40);
      test_sweep(100, 1'b0, 3);
      test_start_abort_idle();
      test_reset_mid_wait();
      test_use_done();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
